soma_arbiter: RTL
=================

Name: soma_arbiter

Overview:
- Controller that shares a single sequential accumulator (counter opA incremented each step, accumulator opB += opA) between two requesters.
- Each requester asks for a job of `len` steps. The block arbitrates round-robin, sequences the accumulator for exactly `len` steps, then returns the sum to the winner with a one-cycle done pulse.
- Sits between requesting control blocks and the accumulator datapath. The datapath registers are embedded in this block.

Parameters:
- WIDTH, 8, width of len inputs, internal counter, accumulator and result.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset (sampled on rising clock edge; 0 = reset)
- req0  in  1  requester 0 job request, held high until done0 is seen
- len0  in  WIDTH  requester 0 step count, must be stable while req0 is high
- req1  in  1  requester 1 job request
- len1  in  WIDTH  requester 1 step count
- gnt0  out  1  high while requester 0's job owns the accumulator
- gnt1  out  1  high while requester 1's job owns the accumulator
- done0  out  1  one-cycle pulse, result valid for requester 0
- done1  out  1  one-cycle pulse, result valid for requester 1
- result  out  WIDTH  job sum, registered, holds until the next done
- busy  out  1  high in RUN and DONE states

Behaviour:
- States: IDLE, RUN, DONE (2-bit encoding, free choice). Registers:
  - state, owner (1 bit), last (1 bit, last granted)
  - cnt, opA, opB (WIDTH each), result
- Reset (reset==0 at a rising edge):
  - state=IDLE; cnt=opA=opB=result=0; last=1 (so req0 wins first).
  - All outputs 0.
  - Reset overrides everything, including mid-RUN; the aborted job produces no done pulse.
- IDLE:
  - No req: stay in IDLE.
  - One req high: that requester wins.
  - Both high: winner = !last.
  - On a win, at the next edge: owner=winner, last=winner, cnt=len of winner, opA=0, opB=0.
  - Next state = RUN if len!=0, else DONE.
- RUN: each cycle opB <= opB+opA, opA <= opA+1, cnt <= cnt-1. Go to DONE on the edge where cnt==1.
- DONE (one cycle):
  - done[owner]=1, result=opB (result register loaded on entry to DONE).
  - Next state IDLE.
- gnt[owner]=1 in RUN and DONE, 0 otherwise. gnt0 and gnt1 are never both high.
- Latency: req sampled in IDLE at cycle T → done at cycle T+len+1 (len=0 → T+1).
- Arithmetic: all sums modulo 2^WIDTH, wrap silently. result = len*(len-1)/2 mod 2^WIDTH.
- Handshake: the requester drops req on the edge where it sees done. IDLE samples the next cycle, so the next job can start 1 cycle after DONE (DONE→IDLE→RUN minimum spacing).
- Changing len or dropping req while granted is a protocol violation. The block ignores it: len is latched at grant and the job runs to completion.
- Req of the non-owner during RUN/DONE is held pending and arbitrated in the next IDLE. Round-robin guarantees alternation under continuous contention.
- result and done outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- Reset then req0=1, len0=5, req1=0 → gnt0 high for 6 cycles (5 RUN + DONE); done0 pulses at T+6 with result=10; gnt1, done1 stay 0.
- Both req0 and req1 high after reset, len0=4, len1=24 → req0 served first (result=6), then req1 (result=276 mod 256=20); done1 follows done0 by 26 cycles.
- Continuous contention, both held high with len=1 each, re-raised after every done → grants alternate 0,1,0,1; every result=0.
- len1=0 → DONE directly one cycle after the grant; done1 with result=0; gnt1 high for exactly 1 cycle.
- Wrap: len0=255 → result=129 after 256 cycles; len0=23 → result=253.
- Reset asserted mid-RUN (len0=10, after 3 steps) → next cycle all outputs 0 and state IDLE; no done0; with req0 still high, the job restarts from scratch and gives result=45.

Source files
------------

// File: rtl/soma_arbiter.sv
// Round-robin arbiter sharing one embedded sequential accumulator between two requesters.
// Each granted job runs len steps (opB += opA, opA++) and returns the sum with a done pulse.
module soma_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] len0,
    input  logic             req1,
    input  logic [WIDTH-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             winner;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

    // Contention goes to whoever was not served last; a lone request simply wins.
    always_comb begin
        winner = (req0 && req1) ? ~last_q : req1;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = winner;
                    last_d  = winner;
                    cnt_d   = winner ? len1 : len0;
                    opa_d   = '0;
                    opb_d   = '0;
                    if (cnt_d != '0) begin
                        state_d = RUN;
                    end else begin
                        state_d  = DONE;
                        result_d = '0;
                    end
                end
            end
            RUN: begin
                opb_d = opb_q + opa_q;
                opa_d = opa_q + WIDTH'(1);
                cnt_d = cnt_q - WIDTH'(1);
                // Result captures the sum including this final step.
                if (cnt_q == WIDTH'(1)) begin
                    state_d  = DONE;
                    result_d = opb_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        gnt0   = busy && !owner_q;
        gnt1   = busy && owner_q;
        done0  = (state_q == DONE) && !owner_q;
        done1  = (state_q == DONE) && owner_q;
        result = result_q;
    end

endmodule
